// File: rtl/uc_axi_master.sv
// Single-outstanding, single-beat AXI master that bridges a simple command/response port.
// Writes issue AW and W together; reads issue AR; the result is held on rsp_* until accepted.
module uc_axi_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 5,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2,
  parameter int MST_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic              cmd_wr_i,
  input  logic              cmd_vld_i,
  output logic              cmd_rdy_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [RESP_W-1:0] rsp_resp_o,
  output logic              rsp_wr_o,
  output logic              rsp_vld_o,
  input  logic              rsp_rdy_i,
  output logic [ID_W-1:0]   m_awid_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [1:0]        m_awburst_o,
  output logic [LEN_W-1:0]  m_awlen_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_wlast_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [ID_W-1:0]   m_bid_i,
  input  logic [RESP_W-1:0] m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  output logic [ID_W-1:0]   m_arid_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [1:0]        m_arburst_o,
  output logic [LEN_W-1:0]  m_arlen_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [ID_W-1:0]   m_rid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [RESP_W-1:0] m_rresp_i,
  input  logic              m_rlast_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o
);

  // state   | meaning
  // IDLE    | cmd_rdy_o high, waiting for a command
  // WR_REQ  | AW and/or W valid still waiting for its handshake
  // WR_RESP | bready high, waiting for the write response
  // RD_REQ  | arvalid high, waiting for arready
  // RD_DATA | rready high, waiting for the read beat
  // RSP     | rsp_vld_o high, holding the result until rsp_rdy_i
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [RESP_W-1:0] SLVERR = RESP_W'(2);

  state_t            r_state;
  logic              r_cmd_rdy;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rsp_vld;
  logic              r_rsp_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [RESP_W-1:0] r_rsp_resp;

  logic w_aw_done;
  logic w_w_done;
  logic w_unused_ids;

  // A channel counts as done if its valid already dropped or it handshakes this cycle.
  assign w_aw_done    = ~r_awvalid | m_awready_i;
  assign w_w_done     = ~r_wvalid | m_wready_i;
  assign w_unused_ids = ^{m_bid_i, m_rid_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd_rdy  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_wr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_vld_i && r_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_addr    <= cmd_addr_i;
            r_wdata   <= cmd_wdata_i;
            if (cmd_wr_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end else begin
            r_cmd_rdy <= 1'b1;
          end
        end
        WR_REQ: begin
          if (m_awready_i) r_awvalid <= 1'b0;
          if (m_wready_i)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid_i) begin
            r_bready   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_resp <= m_bresp_i;
            r_rsp_wr   <= 1'b1;
            r_rsp_vld  <= 1'b1;
            r_state    <= RSP;
          end
        end
        RD_REQ: begin
          if (m_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid_i) begin
            r_rready   <= 1'b0;
            r_rsp_data <= m_rdata_i;
            // a single-beat read must carry rlast; anything else is a slave error
            r_rsp_resp <= m_rlast_i ? m_rresp_i : SLVERR;
            r_rsp_wr   <= 1'b0;
            r_rsp_vld  <= 1'b1;
            r_state    <= RSP;
          end
        end
        RSP: begin
          if (rsp_rdy_i) begin
            r_rsp_vld <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_rdy_o   = r_cmd_rdy;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_resp_o  = r_rsp_resp;
  assign rsp_wr_o    = r_rsp_wr;
  assign rsp_vld_o   = r_rsp_vld;

  assign m_awid_o    = ID_W'(MST_ID);
  assign m_awaddr_o  = r_addr;
  assign m_awburst_o = 2'b01;
  assign m_awlen_o   = '0;
  assign m_awvalid_o = r_awvalid;
  assign m_wdata_o   = r_wdata;
  assign m_wlast_o   = 1'b1;
  assign m_wvalid_o  = r_wvalid;
  assign m_bready_o  = r_bready;

  assign m_arid_o    = ID_W'(MST_ID);
  assign m_araddr_o  = r_addr;
  assign m_arburst_o = 2'b01;
  assign m_arlen_o   = '0;
  assign m_arvalid_o = r_arvalid;
  assign m_rready_o  = r_rready;

endmodule

// File: tb/tb_uc_axi_master.sv
// Self-checking bench for uc_axi_master: directed scenarios plus randomized transactions
// compared against a latency/response model derived from the channel handshake rules.
module tb_uc_axi_master;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 5;
  localparam int LEN_W  = 8;
  localparam int RESP_W = 2;
  localparam int MST_ID = 0;
  localparam int LIMIT  = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              cmd_wr_i, cmd_vld_i, cmd_rdy_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [RESP_W-1:0] rsp_resp_o;
  logic              rsp_wr_o, rsp_vld_o, rsp_rdy_i;
  logic [ID_W-1:0]   m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [ADDR_W-1:0] m_awaddr_o, m_araddr_o;
  logic [1:0]        m_awburst_o, m_arburst_o;
  logic [LEN_W-1:0]  m_awlen_o, m_arlen_o;
  logic              m_awvalid_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i;
  logic [DATA_W-1:0] m_wdata_o, m_rdata_i;
  logic [RESP_W-1:0] m_bresp_i, m_rresp_i;
  logic              m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic              m_rlast_i, m_rvalid_i, m_rready_o;

  uc_axi_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .RESP_W(RESP_W), .MST_ID(MST_ID)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wr_i(cmd_wr_i),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o), .rsp_wr_o(rsp_wr_o),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awburst_o(m_awburst_o),
    .m_awlen_o(m_awlen_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arburst_o(m_arburst_o),
    .m_arlen_o(m_arlen_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  int total = 0;
  int bad   = 0;

  // observations collected by run_txn, judged by the calling test
  logic [ADDR_W-1:0] ob_addr;
  logic [DATA_W-1:0] ob_wdata, ob_rsp_data;
  logic [RESP_W-1:0] ob_rsp_resp;
  logic              ob_rsp_wr;
  int ob_aw_cyc, ob_w_cyc, ob_ar_cyc, ob_rsp_cyc, ob_lat;
  logic ob_timeout, ob_bready_early, ob_unstable, ob_busy_rdy, ob_addr_bad, ob_const_bad;

  task automatic clear_slave();
    m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
    m_bvalid_i = 0; m_bresp_i = '0; m_bid_i = '0;
    m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 0; m_rid_i = '0;
    rsp_rdy_i = 0;
  endtask

  // Acts as command source, AXI slave and response sink for one transaction.
  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                         input int rsp_d, input logic [DATA_W-1:0] rdata,
                         input logic [RESP_W-1:0] resp, input logic rlast);
    logic aw_done, w_done, ar_done, b_done, r_done, fin;
    logic aw_fire, w_fire, ar_fire, b_fire, r_fire, rsp_fire;
    int b_wait, r_wait, cyc;
    ob_addr = '0; ob_wdata = '0; ob_rsp_data = '0; ob_rsp_resp = '0; ob_rsp_wr = 0;
    ob_aw_cyc = 0; ob_w_cyc = 0; ob_ar_cyc = 0; ob_rsp_cyc = 0; ob_lat = 0;
    ob_timeout = 0; ob_bready_early = 0; ob_unstable = 0; ob_busy_rdy = 0;
    ob_addr_bad = 0; ob_const_bad = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0; fin = 0;
    b_wait = 0; r_wait = 0;
    clear_slave();
    cyc = 0;
    while (cmd_rdy_o !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (cmd_rdy_o !== 1'b1) begin
      ob_timeout = 1;
      return;
    end
    cmd_addr_i = addr; cmd_wdata_i = data; cmd_wr_i = wr; cmd_vld_i = 1;
    @(posedge clk); #1;
    cmd_vld_i = 0; cmd_addr_i = $urandom; cmd_wdata_i = DATA_W'($urandom); cmd_wr_i = ~wr;
    for (cyc = 1; cyc <= LIMIT && !fin; cyc++) begin
      if (cmd_rdy_o !== 1'b0) ob_busy_rdy = 1;
      if (m_awvalid_o) begin
        ob_aw_cyc++;
        if (ob_aw_cyc == 1) ob_addr = m_awaddr_o;
        else if (m_awaddr_o !== ob_addr) ob_addr_bad = 1;
        if (m_awlen_o !== '0 || m_awburst_o !== 2'b01 || m_awid_o !== ID_W'(MST_ID)) ob_const_bad = 1;
      end
      m_awready_i = m_awvalid_o && (ob_aw_cyc > aw_d);
      if (m_wvalid_o) begin
        ob_w_cyc++;
        if (ob_w_cyc == 1) ob_wdata = m_wdata_o;
        else if (m_wdata_o !== ob_wdata) ob_addr_bad = 1;
        if (m_wlast_o !== 1'b1) ob_const_bad = 1;
      end
      m_wready_i = m_wvalid_o && (ob_w_cyc > w_d);
      if (m_arvalid_o) begin
        ob_ar_cyc++;
        if (ob_ar_cyc == 1) ob_addr = m_araddr_o;
        else if (m_araddr_o !== ob_addr) ob_addr_bad = 1;
        if (m_arlen_o !== '0 || m_arburst_o !== 2'b01 || m_arid_o !== ID_W'(MST_ID)) ob_const_bad = 1;
      end
      m_arready_i = m_arvalid_o && (ob_ar_cyc > ar_d);
      if (m_bready_o && !(aw_done && w_done)) ob_bready_early = 1;
      if (aw_done && w_done && !b_done) begin
        if (b_wait >= b_d) begin
          m_bvalid_i = 1; m_bresp_i = resp; m_bid_i = ID_W'($urandom);
        end else b_wait++;
      end
      if (ar_done && !r_done) begin
        if (r_wait >= r_d) begin
          m_rvalid_i = 1; m_rdata_i = rdata; m_rresp_i = resp; m_rlast_i = rlast;
          m_rid_i = ID_W'($urandom);
        end else r_wait++;
      end
      if (rsp_vld_o) begin
        ob_rsp_cyc++;
        if (ob_rsp_cyc == 1) begin
          ob_rsp_data = rsp_data_o; ob_rsp_resp = rsp_resp_o; ob_rsp_wr = rsp_wr_o; ob_lat = cyc;
        end else if (rsp_data_o !== ob_rsp_data || rsp_resp_o !== ob_rsp_resp || rsp_wr_o !== ob_rsp_wr)
          ob_unstable = 1;
        rsp_rdy_i = (ob_rsp_cyc > rsp_d);
      end else rsp_rdy_i = 0;
      aw_fire  = m_awvalid_o && m_awready_i;
      w_fire   = m_wvalid_o && m_wready_i;
      ar_fire  = m_arvalid_o && m_arready_i;
      b_fire   = m_bvalid_i && m_bready_o;
      r_fire   = m_rvalid_i && m_rready_o;
      rsp_fire = rsp_vld_o && rsp_rdy_i;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      if (ar_fire) ar_done = 1;
      if (b_fire) begin b_done = 1; m_bvalid_i = 0; end
      if (r_fire) begin r_done = 1; m_rvalid_i = 0; end
      if (rsp_fire) fin = 1;
    end
    if (!fin) ob_timeout = 1;
    clear_slave();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_slave();
    cmd_vld_i = 0; cmd_wr_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_vld_o} !== 6'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 000000",
                      {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_vld_o});
    end
    total++;
    if ({m_awaddr_o, m_wdata_o, rsp_data_o, rsp_resp_o} !== '0) begin
      bad++; $display("FAIL reset_regs: awaddr %h wdata %h rsp_data %h rsp_resp %h want all 0",
                      m_awaddr_o, m_wdata_o, rsp_data_o, rsp_resp_o);
    end
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy_o); end
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 32'h2000_0010, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 2'b00, 1'b1);
    total++;
    if (ob_timeout !== 1'b0) begin bad++; $display("FAIL wr_basic_timeout: got %b want 0", ob_timeout); end
    total++;
    if (ob_addr !== 32'h2000_0010 || ob_wdata !== 8'hA5) begin
      bad++; $display("FAIL wr_basic_addr_data: got %h/%h want 20000010/a5", ob_addr, ob_wdata);
    end
    total++;
    if (ob_aw_cyc !== 1 || ob_w_cyc !== 1) begin
      bad++; $display("FAIL wr_basic_same_cycle_hs: aw %0d w %0d cycles want 1/1", ob_aw_cyc, ob_w_cyc);
    end
    total++;
    if (ob_rsp_wr !== 1'b1 || ob_rsp_resp !== 2'b00 || ob_rsp_data !== 8'h00) begin
      bad++; $display("FAIL wr_basic_rsp: wr %b resp %b data %h want 1/00/00", ob_rsp_wr, ob_rsp_resp, ob_rsp_data);
    end
    total++;
    if (ob_lat !== 3) begin bad++; $display("FAIL wr_basic_latency: got %0d want 3", ob_lat); end
    total++;
    if (ob_const_bad !== 1'b0) begin bad++; $display("FAIL wr_basic_len_burst_id_last: got %b want 0", ob_const_bad); end
    #0;
    total++;
    if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL wr_basic_back_idle: cmd_rdy %b want 1", cmd_rdy_o); end
  endtask

  task automatic test_write_aw_delay();
    run_txn(1'b1, 32'h1234_5678, 8'h5A, 3, 0, 1, 0, 0, 0, 8'h00, 2'b11, 1'b1);
    total++;
    if (ob_w_cyc !== 1 || ob_aw_cyc !== 4) begin
      bad++; $display("FAIL wr_awdelay_valid_len: w %0d aw %0d cycles want 1/4", ob_w_cyc, ob_aw_cyc);
    end
    total++;
    if (ob_bready_early !== 1'b0) begin bad++; $display("FAIL wr_awdelay_bready_early: got %b want 0", ob_bready_early); end
    total++;
    if (ob_rsp_resp !== 2'b11 || ob_rsp_wr !== 1'b1 || ob_addr_bad !== 1'b0) begin
      bad++; $display("FAIL wr_awdelay_rsp: resp %b wr %b addr_unstable %b want 11/1/0",
                      ob_rsp_resp, ob_rsp_wr, ob_addr_bad);
    end
  endtask

  task automatic test_read_basic();
    run_txn(1'b0, 32'h2000_0020, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C, 2'b00, 1'b1);
    total++;
    if (ob_addr !== 32'h2000_0020 || ob_ar_cyc !== 1) begin
      bad++; $display("FAIL rd_basic_ar: addr %h cycles %0d want 20000020/1", ob_addr, ob_ar_cyc);
    end
    total++;
    if (ob_rsp_data !== 8'h3C || ob_rsp_resp !== 2'b00 || ob_rsp_wr !== 1'b0) begin
      bad++; $display("FAIL rd_basic_rsp: data %h resp %b wr %b want 3c/00/0", ob_rsp_data, ob_rsp_resp, ob_rsp_wr);
    end
    total++;
    if (ob_lat !== 3) begin bad++; $display("FAIL rd_basic_latency: got %0d want 3", ob_lat); end
  endtask

  task automatic test_read_no_rlast();
    run_txn(1'b0, 32'h0000_0044, 8'h00, 1, 0, 0, 1, 2, 0, 8'hC3, 2'b00, 1'b0);
    total++;
    if (ob_rsp_resp !== 2'b10 || ob_rsp_data !== 8'hC3) begin
      bad++; $display("FAIL rd_no_rlast: resp %b data %h want 10/c3", ob_rsp_resp, ob_rsp_data);
    end
  endtask

  task automatic test_rsp_backpressure();
    run_txn(1'b0, 32'h0000_0100, 8'h00, 0, 0, 0, 0, 0, 5, 8'h96, 2'b01, 1'b1);
    total++;
    if (ob_rsp_cyc !== 6 || ob_unstable !== 1'b0) begin
      bad++; $display("FAIL rsp_hold: vld cycles %0d unstable %b want 6/0", ob_rsp_cyc, ob_unstable);
    end
    total++;
    if (ob_busy_rdy !== 1'b0) begin bad++; $display("FAIL rsp_hold_cmd_rdy: busy cmd_rdy seen %b want 0", ob_busy_rdy); end
    total++;
    if (ob_rsp_data !== 8'h96 || ob_rsp_resp !== 2'b01) begin
      bad++; $display("FAIL rsp_hold_value: data %h resp %b want 96/01", ob_rsp_data, ob_rsp_resp);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic spurious;
    clear_slave();
    n = 0;
    while (cmd_rdy_o !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    cmd_addr_i = 32'h0BAD_0000; cmd_wdata_i = 8'h77; cmd_wr_i = 1; cmd_vld_i = 1;
    @(posedge clk); #1;
    cmd_vld_i = 0;
    m_awready_i = 1; m_wready_i = 1;
    n = 0;
    while (m_bready_o !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (m_bready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_wr_resp: bready %b want 1", m_bready_o); end
    m_awready_i = 0; m_wready_i = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_vld_o} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_async: got %b want 000000",
                      {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_vld_o});
    end
    m_bvalid_i = 1; m_bresp_i = 2'b00;
    @(posedge clk); #1;
    rst_n = 1;
    spurious = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_vld_o !== 1'b0) spurious = 1;
    end
    m_bvalid_i = 0;
    total++;
    if (spurious !== 1'b0) begin bad++; $display("FAIL rst_mid_spurious_rsp: got %b want 0", spurious); end
    total++;
    if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL rst_mid_idle: cmd_rdy %b want 1", cmd_rdy_o); end
  endtask

  task automatic test_random();
    logic wr, rlast;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data, rdata, exp_data;
    logic [RESP_W-1:0] resp, exp_resp;
    int aw_d, w_d, b_d, ar_d, r_d, rsp_d, exp_lat, hs;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); addr = $urandom; data = DATA_W'($urandom);
      rdata = DATA_W'($urandom); resp = RESP_W'($urandom_range(0, 3));
      rlast = ($urandom_range(0, 3) != 0);
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3); rsp_d = $urandom_range(0, 2);
      run_txn(wr, addr, data, aw_d, w_d, b_d, ar_d, r_d, rsp_d, rdata, resp, rlast);
      exp_data = wr ? '0 : rdata;
      exp_resp = (!wr && !rlast) ? 2'b10 : resp;
      hs = (aw_d > w_d) ? aw_d : w_d;
      exp_lat = wr ? hs + b_d + 3 : ar_d + r_d + 3;
      total++;
      if (ob_timeout !== 1'b0) begin bad++; $display("FAIL rnd%0d_timeout: got %b want 0", i, ob_timeout); end
      total++;
      if (ob_rsp_data !== exp_data || ob_rsp_resp !== exp_resp || ob_rsp_wr !== wr) begin
        bad++; $display("FAIL rnd%0d_rsp: data %h resp %b wr %b want %h/%b/%b",
                        i, ob_rsp_data, ob_rsp_resp, ob_rsp_wr, exp_data, exp_resp, wr);
      end
      total++;
      if (ob_addr !== addr || (wr && ob_wdata !== data)) begin
        bad++; $display("FAIL rnd%0d_addr_data: addr %h wdata %h want %h/%h", i, ob_addr, ob_wdata, addr, data);
      end
      total++;
      if (ob_aw_cyc !== (wr ? aw_d + 1 : 0) || ob_w_cyc !== (wr ? w_d + 1 : 0) || ob_ar_cyc !== (wr ? 0 : ar_d + 1)) begin
        bad++; $display("FAIL rnd%0d_valid_cycles: aw %0d w %0d ar %0d wr %b dly %0d/%0d/%0d",
                        i, ob_aw_cyc, ob_w_cyc, ob_ar_cyc, wr, aw_d, w_d, ar_d);
      end
      total++;
      if (ob_lat !== exp_lat || ob_rsp_cyc !== rsp_d + 1) begin
        bad++; $display("FAIL rnd%0d_timing: lat %0d rsp_cyc %0d want %0d/%0d", i, ob_lat, ob_rsp_cyc, exp_lat, rsp_d + 1);
      end
      total++;
      if ({ob_bready_early, ob_unstable, ob_busy_rdy, ob_addr_bad, ob_const_bad} !== 5'b0) begin
        bad++; $display("FAIL rnd%0d_protocol: flags %b want 00000", i,
                        {ob_bready_early, ob_unstable, ob_busy_rdy, ob_addr_bad, ob_const_bad});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_basic();
    test_read_no_rlast();
    test_rsp_backpressure();
    test_reset_mid_write();
    test_read_basic();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uc_axi_master.md
UC_AXI_MASTER -- requirements
Module: uc_axi_master

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 8, data width.
- ADDR_W, 32, address width.
- ID_W, 5, transaction ID width.
- LEN_W, 8, burst length width.
- RESP_W, 2, response width.
- MST_ID, 0, constant ID driven on m_awid_o and m_arid_o.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- cmd_addr_i, in, ADDR_W, target byte address.
- cmd_wdata_i, in, DATA_W, write data; ignored on reads.
- cmd_wr_i, in, 1, 1 = write, 0 = read.
- cmd_vld_i, in, 1, command valid.
- cmd_rdy_o, out, 1, command ready.
- rsp_data_o, out, DATA_W, read data; 0 on writes.
- rsp_resp_o, out, RESP_W, BRESP or RRESP.
- rsp_wr_o, out, 1, response belongs to a write.
- rsp_vld_o, out, 1, response valid.
- rsp_rdy_i, in, 1, response ready.
- AW channel: m_awid_o (out, ID_W), m_awaddr_o (out, ADDR_W), m_awburst_o (out, 2), m_awlen_o (out, LEN_W), m_awvalid_o (out, 1), m_awready_i (in, 1).
- W channel: m_wdata_o (out, DATA_W), m_wlast_o (out, 1), m_wvalid_o (out, 1), m_wready_i (in, 1).
- B channel: m_bid_i (in, ID_W), m_bresp_i (in, RESP_W), m_bvalid_i (in, 1), m_bready_o (out, 1).
- AR channel: m_arid_o (out, ID_W), m_araddr_o (out, ADDR_W), m_arburst_o (out, 2), m_arlen_o (out, LEN_W), m_arvalid_o (out, 1), m_arready_i (in, 1).
- R channel: m_rid_i (in, ID_W), m_rdata_i (in, DATA_W), m_rresp_i (in, RESP_W), m_rlast_i (in, 1), m_rvalid_i (in, 1), m_rready_o (out, 1).

Function
REQ-003 One outstanding transaction at a time; every transaction is single-beat: len = 0, burst = INCR (2'b01), wlast = 1.
REQ-004 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-005 cmd_rdy_o = 1 only in IDLE; on cmd_vld_i & cmd_rdy_o, register addr, wdata and wr; go to WR_REQ if cmd_wr_i = 1, else RD_REQ.
REQ-006 Outputs m_*addr_o, m_wdata_o, m_*id_o, m_*len_o, m_*burst_o are registered and stay stable while the corresponding valid is high.
REQ-007 WR_REQ, entry: m_awvalid_o and m_wvalid_o rise together on the cycle after command accept.
- Each valid drops on the cycle after its own handshake (valid & ready), independent of the other.
- Handshakes in the same cycle are legal.
- Go to WR_RESP once both handshakes are complete.
REQ-008 WR_RESP: m_bready_o = 1; on m_bvalid_i, capture m_bresp_i, set rsp_data = 0 and rsp_wr = 1, go to RSP.
REQ-009 RD_REQ: m_arvalid_o = 1 until m_arready_i, then go to RD_DATA.
REQ-010 RD_DATA: m_rready_o = 1; on m_rvalid_i, capture m_rdata_i and m_rresp_i, set rsp_wr = 0, go to RSP.
REQ-011 m_rlast_i = 0 with m_rvalid_i: rsp_resp_o forced to SLVERR (2'b10); data still captured.
REQ-012 RSP: rsp_vld_o = 1, outputs held stable; on rsp_rdy_i, go to IDLE.
- Minimum write latency, cmd accept to rsp_vld_o with ready slave: 3 cycles.
- Minimum read latency: 3 cycles.
REQ-013 m_bid_i and m_rid_i are not checked.
REQ-014 Valids never drop before their handshake; valids never depend combinationally on ready.

Reset
REQ-015 rst_n low, asynchronously:
- FSM goes to IDLE.
- All valids, m_bready_o, m_rready_o, rsp_vld_o and all data/addr registers go to 0.
- cmd_rdy_o goes to 1 after reset release.
REQ-016 Reset mid-transaction abandons the transaction; no response is produced for it.

Verification
REQ-017 Write cmd addr 0x2000_0010, data 0xA5, slave always ready:
- AW and W handshake in the same cycle, awaddr 0x2000_0010, wdata 0xA5.
- BRESP 0 gives rsp_vld_o with rsp_wr_o = 1 and rsp_resp_o = 0.
REQ-018 Write with awready delayed 3 cycles and wready immediate:
- wvalid drops after 1 cycle; awvalid holds 4 cycles.
- bready asserts only after both handshakes.
REQ-019 Read addr 0x2000_0020, slave returns rdata 0x3C, rlast = 1, RRESP 0:
- rsp_data_o = 0x3C, rsp_resp_o = 0.
REQ-020 Read returning rlast = 0 -> rsp_resp_o = 2'b10.
REQ-021 rsp_rdy_i held low 5 cycles:
- rsp_vld_o and rsp_data_o stable for all 5 cycles.
- cmd_rdy_o = 0 until the response handshake.
REQ-022 rst_n asserted during WR_RESP:
- All valids go to 0 immediately.
- After release, IDLE with cmd_rdy_o = 1 and no spurious rsp_vld_o.
